yrv_boot_loader_ctl: RTL and testbench

- Sequences program load into the yrv_soc instruction/data memory from the auxiliary UART (BOOT_FROM_AUX_UART build).
- Assembles received bytes into little-endian 32-bit words and issues handshaked word writes to the memory write port.
- Holds the CPU in reset until the stream ends on an idle timeout, then releases the CPU and the memory port.
- Sits between the aux UART receiver and the memory write port.

---
 rtl/yrv_boot_loader_ctl.sv | 109 ++++++++++
 tb/tb_yrv_boot_loader_ctl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/yrv_boot_loader_ctl.sv
// yrv_boot_loader_ctl: loads little-endian words from the aux UART into memory, holding the CPU in reset until the stream idles out.
module yrv_boot_loader_ctl #(
    parameter int ADDR_W       = 12,
    parameter int IDLE_TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boot_en,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    input  logic              mem_wr_ack,
    output logic              cpu_hold,
    output logic              boot_done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_overrun,
    output logic              err_partial,
    output logic              err_overflow
);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_FIRST, LOAD, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       shift_q, shift_d;
    logic [IW-1:0]     idle_q, idle_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovr_q, ovr_d, par_q, par_d, ofl_q, ofl_d;
    logic              take, word_done, full, timeout, issue;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            idle_q     <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            count_q    <= '0;
            ovr_q      <= 1'b0;
            par_q      <= 1'b0;
            ofl_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            idle_q     <= idle_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            count_q    <= count_d;
            ovr_q      <= ovr_d;
            par_q      <= par_d;
            ofl_q      <= ofl_d;
        end
    end

    always_comb begin
        take    = rx_valid && (state_q == WAIT_FIRST || state_q == LOAD);
        timeout = state_q == LOAD && !rx_valid && idle_q == IDLE_MAX;
        state_d = state_q;
        case (state_q)
            IDLE:       state_d = boot_en ? WAIT_FIRST : DONE;
            WAIT_FIRST: state_d = rx_valid ? LOAD : WAIT_FIRST;
            LOAD:       state_d = (timeout && !req_q) ? DONE : LOAD;
            default:    state_d = DONE;
        endcase
    end

    // Any write still requested (even one acked this cycle) blocks a new word.
    always_comb begin
        word_done  = take && byte_cnt_q == 2'd3;
        full       = count_q[ADDR_W];
        issue      = word_done && !req_q && !full;
        byte_cnt_d = take ? byte_cnt_q + 2'd1 : byte_cnt_q;
        shift_d    = shift_q;
        if (take)
            shift_d[8*byte_cnt_q +: 8] = rx_data;
        idle_d     = (state_q == LOAD && !rx_valid) ? (timeout ? idle_q : idle_q + IW'(1)) : '0;
        req_d      = issue || (req_q && !mem_wr_ack);
        addr_d     = issue ? count_q[ADDR_W-1:0] : addr_q;
        data_d     = issue ? {rx_data, shift_q[23:0]} : data_q;
        count_d    = (req_q && mem_wr_ack && !full) ? count_q + (ADDR_W+1)'(1) : count_q;
        ovr_d      = ovr_q || (word_done && req_q);
        ofl_d      = ofl_q || (word_done && !req_q && full);
        par_d      = par_q || (timeout && !req_q && byte_cnt_q != 2'd0);
    end

    always_comb begin
        cpu_hold  = state_q != DONE;
        boot_done = state_q == DONE;
    end

    assign mem_wr_req   = req_q;
    assign mem_wr_addr  = addr_q;
    assign mem_wr_data  = data_q;
    assign word_count   = count_q;
    assign err_overrun  = ovr_q;
    assign err_partial  = par_q;
    assign err_overflow = ofl_q;
endmodule

// File: tb/tb_yrv_boot_loader_ctl.sv
// tb_yrv_boot_loader_ctl: directed bench with a cycle-level reference model and literal spot checks.
module tb_yrv_boot_loader_ctl;
    localparam int AW = 2;
    localparam int T = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1, boot_en = 1'b0, rx_valid = 1'b0, mem_wr_ack = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          mem_wr_req, cpu_hold, boot_done, err_overrun, err_partial, err_overflow;
    logic [AW-1:0] mem_wr_addr;
    logic [31:0]   mem_wr_data;
    logic [AW:0]   word_count;

    int checks = 0, errors = 0;
    bit chk_en = 0;
    logic [63:0] wlog[$];

    yrv_boot_loader_ctl #(.ADDR_W(AW), .IDLE_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .boot_en(boot_en), .rx_valid(rx_valid), .rx_data(rx_data),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ack(mem_wr_ack), .cpu_hold(cpu_hold), .boot_done(boot_done),
        .word_count(word_count), .err_overrun(err_overrun), .err_partial(err_partial),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 waiting for first byte, 2 loading, 3 done.
    int          m_phase, m_nb, m_quiet, m_cnt, m_addr;
    bit          m_req, m_ovr, m_par, m_ofl, had_req, issue;
    logic [31:0] m_word, m_data;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_nb = 0; m_quiet = 0; m_cnt = 0; m_addr = 0;
            m_req = 0; m_ovr = 0; m_par = 0; m_ofl = 0; m_word = 0; m_data = 0;
        end else begin
            had_req = m_req;
            issue = 0;
            if (m_phase == 0) m_phase = boot_en ? 1 : 3;
            else if ((m_phase == 1 || m_phase == 2) && rx_valid) begin
                m_phase = 2;
                m_word[8*m_nb +: 8] = rx_data;
                m_nb++;
                m_quiet = 0;
                if (m_nb == 4) begin
                    m_nb = 0;
                    if (had_req) m_ovr = 1;
                    else if (m_cnt == DEPTH) m_ofl = 1;
                    else issue = 1;
                end
            end else if (m_phase == 2) begin
                if (m_quiet >= T - 1 && !had_req) begin
                    m_phase = 3;
                    if (m_nb != 0) m_par = 1;
                end else m_quiet++;
            end
            if (had_req && mem_wr_ack) begin
                m_req = 0;
                m_cnt++;
            end
            if (issue) begin
                m_req = 1;
                m_addr = m_cnt;
                m_data = m_word;
            end
        end
    end

    always @(posedge clk)
        if (!reset && mem_wr_req && mem_wr_ack) wlog.push_back({30'd0, mem_wr_addr, mem_wr_data});

    always @(negedge clk) if (chk_en) begin
        chk("cpu_hold", cpu_hold, m_phase != 3);
        chk("boot_done", boot_done, m_phase == 3);
        chk("req", mem_wr_req, m_req);
        chk("addr", mem_wr_addr, m_addr);
        chk("data", mem_wr_data, m_data);
        chk("count", word_count, m_cnt);
        chk("overrun", err_overrun, m_ovr);
        chk("partial", err_partial, m_par);
        chk("overflow", err_overflow, m_ofl);
    end

    task automatic do_reset(input logic en, input logic ack);
        @(negedge clk);
        reset = 1; rx_valid = 0; boot_en = en; mem_wr_ack = ack;
        @(negedge clk);
        reset = 0;
        wlog.delete();
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1; rx_data = b;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        @(negedge clk);
        rx_valid = 0;
        while (!boot_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!boot_done) chk("done_timeout", 0, 1);
    endtask

    int n;
    logic [7:0] prog[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    initial begin
        @(negedge clk); @(negedge clk);
        chk_en = 1;
        chk("rst_hold", cpu_hold, 1);
        chk("rst_count", word_count, 0);
        // boot disabled: release straight to DONE
        reset = 0;
        chk("nb_hold_before", cpu_hold, 1);
        @(negedge clk);
        chk("nb_done", boot_done, 1);
        chk("nb_hold", cpu_hold, 0);
        repeat (3) @(negedge clk);
        chk("nb_no_write", wlog.size(), 0);

        do_reset(1, 1);
        repeat (3) @(negedge clk);
        foreach (prog[i]) put(prog[i]);
        wait_done(n);
        chk("t2_latency", n, T);
        chk("t2_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("t2_w0", wlog[0], {32'd0, 32'h0000_0013});
            chk("t2_w1", wlog[1], {32'd1, 32'h0010_0093});
        end
        chk("t2_count", word_count, 2);
        chk("t2_errs", {err_overrun, err_partial, err_overflow}, 0);

        do_reset(1, 0);
        put(8'h11); put(8'h22); put(8'h33); put(8'h44);
        @(negedge clk);
        rx_valid = 0;
        chk("t3_req", mem_wr_req, 1);
        repeat (4) @(negedge clk);
        chk("t3_req_held", mem_wr_req, 1);
        chk("t3_count_held", word_count, 0);
        mem_wr_ack = 1;
        @(negedge clk);
        mem_wr_ack = 0;
        chk("t3_req_drop", mem_wr_req, 0);
        chk("t3_count", word_count, 1);
        chk("t3_w0", wlog.size() == 1 ? wlog[0] : 64'hx, {32'd0, 32'h4433_2211});

        do_reset(1, 0);
        for (int i = 0; i < 8; i++) put(8'(i + 1));
        @(negedge clk);
        rx_valid = 0;
        mem_wr_ack = 1;
        @(negedge clk);
        mem_wr_ack = 0;
        wait_done(n);
        chk("t4_overrun", err_overrun, 1);
        chk("t4_count", word_count, 1);
        chk("t4_w0", wlog.size() == 1 ? wlog[0] : 64'hx, {32'd0, 32'h0403_0201});

        do_reset(1, 1);
        for (int i = 0; i < 6; i++) put(8'(8'hA0 + i));
        wait_done(n);
        chk("t5_partial", err_partial, 1);
        chk("t5_count", word_count, 1);
        chk("t5_done", boot_done, 1);

        do_reset(1, 1);
        for (int i = 0; i < 20; i++) put(8'(i));
        wait_done(n);
        chk("t6_overflow", err_overflow, 1);
        chk("t6_count", word_count, DEPTH);
        chk("t6_nwrites", wlog.size(), DEPTH);
        if (wlog.size() == DEPTH) chk("t6_w3", wlog[3], {32'd3, 32'h0f0e_0d0c});

        // reset with a write pending mid-stream
        do_reset(1, 0);
        for (int i = 0; i < 5; i++) put(8'hC0);
        @(negedge clk);
        chk("t7_req_before", mem_wr_req, 1);
        reset = 1; rx_valid = 0;
        @(negedge clk);
        chk("t7_req", mem_wr_req, 0);
        chk("t7_hold", cpu_hold, 1);
        chk("t7_data", mem_wr_data, 0);
        chk("t7_done", boot_done, 0);
        reset = 0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
